// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer
//   Packs the RTU's 24-bit RGB pixel stream into 32-bit words. Bytes go out in
//   the order red, green, blue and fill the word from tdata[7:0] upward,
//   continuing across pixel boundaries. A pixel flagged end-of-line flushes any
//   leftover bytes as a zero-padded word, and the last word of the line carries
//   m_tlast. The first word pushed after a start-of-frame pixel carries m_tuser.
//   Words are queued in a small FIFO. The RTU is stalled unless the FIFO has
//   room for two words, which is the most that one pixel can produce.
//
// Parameters
//   FIFO_DEPTH  output word FIFO depth in words (power of two, >= 2)
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-low reset
//   pix_valid/ready   pixel handshake (pix_ready drives the RTU's ReadyExternal)
//   pix_red/green/blue pixel channels
//   pix_sof, pix_eol  first pixel of frame, last pixel of line
//   m_tdata/tvalid/tready/tlast/tuser  AXI4-Stream-style word output
//   protocol_error    sticky flag, only built when PACKER_PROTOCOL_CHECK_EN is defined
//
// Optional feature macro: PACKER_PROTOCOL_CHECK_EN
//   Defined   : protocol_error latches when pix_sof is accepted mid-word or
//               while a line is still open.
//   Undefined : protocol_error is tied low.
module pixel_stream_packer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_red,
    input  logic [7:0]  pix_green,
    input  logic [7:0]  pix_blue,
    input  logic        pix_sof,
    input  logic        pix_eol,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        protocol_error
);

    localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    // State name = number of residual bytes held in the accumulator
    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_e;

    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [31:0] tdata;
    } word_t;

    phase_e        state_q, state_d;
    logic [23:0]   acc_q, acc_d;
    logic          sof_pend_q, sof_pend_d;
    word_t         mem_q [FIFO_DEPTH];
    word_t         mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    word_t         last_q, last_d;

    logic          pix_accept;
    logic          pop;
    logic [1:0]    n_res;
    logic [5:0]    shamt;
    logic [47:0]   combined;
    logic          emit;
    logic [1:0]    res_after;
    logic [23:0]   res_bytes;
    logic          sof_eff;
    word_t         word0, word1;
    logic [1:0]    n_push;
    word_t         head;

    // Two free slots are needed because an end-of-line pixel can push two words
    assign pix_ready  = reset && ((CW'(FIFO_DEPTH) - count_q) >= CW'(2));
    assign pix_accept = pix_valid && pix_ready;

    assign m_tvalid = reset && (count_q != '0);
    assign pop      = m_tvalid && m_tready;
    assign head     = mem_q[rd_ptr_q];

    // With the FIFO empty the outputs keep showing the most recently popped word
    assign m_tdata  = (count_q != '0) ? head.tdata : last_q.tdata;
    assign m_tlast  = (count_q != '0) ? head.tlast : last_q.tlast;
    assign m_tuser  = (count_q != '0) ? head.tuser : last_q.tuser;

    // Packing datapath: residual bytes sit in the low lanes of acc_q with the
    // unused upper bytes kept at zero, so the new pixel can be OR-ed in above them.
    always_comb begin
        n_res     = 2'd0;
        case (state_q)
            P0:      n_res = 2'd0;
            P1:      n_res = 2'd1;
            P2:      n_res = 2'd2;
            P3:      n_res = 2'd3;
            default: n_res = 2'd0;
        endcase
        shamt     = {1'b0, n_res, 3'b000};
        combined  = {24'h000000, acc_q}
                  | ({24'h000000, pix_blue, pix_green, pix_red} << shamt);
        emit      = (n_res != 2'd0);
        res_after = emit ? (n_res - 2'd1) : 2'd3;
        res_bytes = emit ? {8'h00, combined[47:32]} : combined[23:0];
    end

    // Word generation and start-of-frame tagging
    always_comb begin
        word0      = '0;
        word1      = '0;
        n_push     = 2'd0;
        sof_eff    = sof_pend_q || (pix_accept && pix_sof);
        if (pix_accept) begin
            if (emit) begin
                word0.tdata = combined[31:0];
                n_push      = 2'd1;
                if (pix_eol && (res_after != 2'd0)) begin
                    word1.tdata = {8'h00, res_bytes};
                    word1.tlast = 1'b1;
                    n_push      = 2'd2;
                end else begin
                    word0.tlast = pix_eol;
                end
            end else if (pix_eol) begin
                word0.tdata = {8'h00, res_bytes};
                word0.tlast = 1'b1;
                n_push      = 2'd1;
            end
        end
        // Only the first word of a two-word push can carry the frame start
        word0.tuser = sof_eff;
        sof_pend_d  = (n_push != 2'd0) ? 1'b0 : sof_eff;
    end

    // Phase FSM next state
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        if (pix_accept) begin
            if (pix_eol) begin
                state_d = P0;
                acc_d   = '0;
            end else begin
                acc_d = res_bytes;
                case (res_after)
                    2'd0:    state_d = P0;
                    2'd1:    state_d = P1;
                    2'd2:    state_d = P2;
                    default: state_d = P3;
                endcase
            end
        end
    end

    // Output FIFO bookkeeping
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(n_push);
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (n_push != 2'd0) begin
            mem_d[wr_ptr_q] = word0;
        end
        if (n_push == 2'd2) begin
            mem_d[wr_ptr_q + AW'(1)] = word1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            last_d   = head;
        end
        count_d = count_q + CW'(n_push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= P0;
            acc_q      <= '0;
            sof_pend_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sof_pend_q <= sof_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
            mem_q      <= mem_d;
        end
    end

`ifdef PACKER_PROTOCOL_CHECK_EN
    logic line_open_q, line_open_d;
    logic proto_err_q, proto_err_d;

    // A line is open from its first accepted pixel until its eol pixel
    always_comb begin
        line_open_d = line_open_q;
        proto_err_d = proto_err_q;
        if (pix_accept) begin
            if (pix_sof && ((state_q != P0) || line_open_q)) begin
                proto_err_d = 1'b1;
            end
            line_open_d = !pix_eol;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            line_open_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            line_open_q <= line_open_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign protocol_error = proto_err_q;
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_stream_packer.sv
module tb_pixel_stream_packer;

    localparam int unsigned FIFO_DEPTH = 4;
`ifdef PACKER_PROTOCOL_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  pix_red = '0;
    logic [7:0]  pix_green = '0;
    logic [7:0]  pix_blue = '0;
    logic        pix_sof = 1'b0;
    logic        pix_eol = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        m_tuser;
    logic        protocol_error;

    pixel_stream_packer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_red        (pix_red),
        .pix_green      (pix_green),
        .pix_blue       (pix_blue),
        .pix_sof        (pix_sof),
        .pix_eol        (pix_eol),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .m_tuser        (m_tuser),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
    } exp_word_t;

    exp_word_t   expq[$];
    exp_word_t   rcvq[$];
    logic [7:0]  byteq[$];
    bit          pend = 1'b0;
    int unsigned n_acc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    bit          rand_ready = 1'b0;

    // Reference model: a plain byte queue cut into 4-byte words, padded at end of line.
    // Handshakes are sampled on the falling edge, half a cycle before they complete.
    always @(negedge clk) begin
        exp_word_t e;
        if (!reset) begin
            byteq.delete();
            expq.delete();
            rcvq.delete();
            pend = 1'b0;
        end else begin
            if (m_tvalid && m_tready) begin
                e.d = m_tdata;
                e.l = m_tlast;
                e.u = m_tuser;
                rcvq.push_back(e);
            end
            if (pix_valid && pix_ready) begin
                n_acc++;
                if (pix_sof) pend = 1'b1;
                byteq.push_back(pix_red);
                byteq.push_back(pix_green);
                byteq.push_back(pix_blue);
                while (byteq.size() >= 4) begin
                    e.d = {byteq[3], byteq[2], byteq[1], byteq[0]};
                    e.l = 1'b0;
                    e.u = pend;
                    pend = 1'b0;
                    repeat (4) void'(byteq.pop_front());
                    expq.push_back(e);
                end
                if (pix_eol) begin
                    if (byteq.size() > 0) begin
                        e.d = '0;
                        for (int i = 0; i < byteq.size(); i++) e.d[8*i +: 8] = byteq[i];
                        e.l = 1'b1;
                        e.u = pend;
                        pend = 1'b0;
                        byteq.delete();
                        expq.push_back(e);
                    end else begin
                        e = expq.pop_back();
                        e.l = 1'b1;
                        expq.push_back(e);
                    end
                end
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        if (rand_ready) m_tready = 1'($urandom_range(0, 1));
    endtask

    // Entered and left at posedge+1; returns after the edge that accepted the pixel.
    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input bit sof, input bit eol);
        bit done = 1'b0;
        int unsigned waited = 0;
        pix_valid = 1'b1;
        pix_red   = r;
        pix_green = g;
        pix_blue  = b;
        pix_sof   = sof;
        pix_eol   = eol;
        while (!done) begin
            @(negedge clk);
            done = pix_ready;
            @(posedge clk);
            #1;
            if (rand_ready) m_tready = 1'($urandom_range(0, 1));
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout: pix_ready stuck at %b, required 1 within 200 cycles", pix_ready);
                    done = 1'b1;
                end
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eol   = 1'b0;
    endtask

    task automatic drain();
        int unsigned w = 0;
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        while ((m_tvalid || (rcvq.size() != expq.size())) && (w < 300)) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: received %0d words, required %0d", rcvq.size(), expq.size());
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready); end
        n_checks++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        n_checks++;
        if (m_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
        n_checks++;
        if (m_tlast !== 1'b0 || m_tuser !== 1'b0) begin
            n_fail++; $display("FAIL reset_tlast_tuser: got %b%b want 00", m_tlast, m_tuser);
        end
        n_checks++;
        if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL reset_proto: got %b want 0", protocol_error); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", pix_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        exp_word_t want[6];
        want[0] = '{32'h04030201, 1'b0, 1'b1};
        want[1] = '{32'h08070605, 1'b0, 1'b0};
        want[2] = '{32'h0C0B0A09, 1'b1, 1'b0};
        want[3] = '{32'h04030201, 1'b0, 1'b0};
        want[4] = '{32'h00000605, 1'b1, 1'b0};
        want[5] = '{32'h00332211, 1'b1, 1'b1};
        rcvq.delete();
        expq.delete();
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        send_pixel(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
        send_pixel(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
        send_pixel(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
        send_pixel(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b1);
        send_pixel(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
        send_pixel(8'h04, 8'h05, 8'h06, 1'b0, 1'b1);
        drain();
        m_tready = 1'b0;
        send_pixel(8'h11, 8'h22, 8'h33, 1'b1, 1'b1);
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h00332211 || m_tlast !== 1'b1 || m_tuser !== 1'b1) begin
            n_fail++;
            $display("FAIL one_pixel_head: got v=%b d=%h l=%b u=%b want v=1 d=00332211 l=1 u=1",
                     m_tvalid, m_tdata, m_tlast, m_tuser);
        end
        drain();
        n_checks++;
        if (rcvq.size() != 6) begin n_fail++; $display("FAIL directed_count: got %0d want 6", rcvq.size()); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= rcvq.size()) begin
                n_fail++;
                $display("FAIL directed_word%0d: missing, want %h", i, want[i].d);
            end else if (rcvq[i].d !== want[i].d || rcvq[i].l !== want[i].l || rcvq[i].u !== want[i].u) begin
                n_fail++;
                $display("FAIL directed_word%0d: got %h l=%b u=%b want %h l=%b u=%b",
                         i, rcvq[i].d, rcvq[i].l, rcvq[i].u, want[i].d, want[i].l, want[i].u);
            end
        end
        n_checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 32'h00332211 || m_tlast !== 1'b1 || m_tuser !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_hold: got v=%b d=%h l=%b u=%b want v=0 d=00332211 l=1 u=1",
                     m_tvalid, m_tdata, m_tlast, m_tuser);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] base;
        rcvq.delete();
        expq.delete();
        n_acc      = 0;
        rand_ready = 1'b0;
        m_tready   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            base = 8'(8'h20 + 3 * k);
            send_pixel(base, 8'(base + 1), 8'(base + 2), k == 0, 1'b0);
        end
        n_checks++;
        if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %b want 0", pix_ready); end
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h23222120 || m_tuser !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_head: got v=%b d=%h u=%b want v=1 d=23222120 u=1", m_tvalid, m_tdata, m_tuser);
        end
        pix_valid = 1'b1;
        pix_red   = 8'h2C;
        pix_green = 8'h2D;
        pix_blue  = 8'h2E;
        repeat (5) idle_cycle();
        n_checks++;
        if (pix_ready !== 1'b0 || n_acc != 4) begin
            n_fail++; $display("FAIL bp_stall: got ready=%b accepted=%0d want ready=0 accepted=4", pix_ready, n_acc);
        end
        n_checks++;
        if (m_tdata !== 32'h23222120 || m_tvalid !== 1'b1) begin
            n_fail++; $display("FAIL bp_head_stable: got v=%b d=%h want v=1 d=23222120", m_tvalid, m_tdata);
        end
        pix_valid = 1'b0;
        m_tready  = 1'b1;
        for (int k = 4; k < 8; k++) begin
            base = 8'(8'h20 + 3 * k);
            send_pixel(base, 8'(base + 1), 8'(base + 2), 1'b0, k == 7);
        end
        drain();
        n_checks++;
        if (rcvq.size() != 6 || expq.size() != 6) begin
            n_fail++; $display("FAIL bp_count: got %0d want 6", rcvq.size());
        end
        for (int i = 0; i < expq.size(); i++) begin
            n_checks++;
            if (i >= rcvq.size()) begin
                n_fail++; $display("FAIL bp_word%0d: missing, want %h", i, expq[i].d);
            end else if (rcvq[i].d !== expq[i].d || rcvq[i].l !== expq[i].l || rcvq[i].u !== expq[i].u) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h l=%b u=%b want %h l=%b u=%b",
                         i, rcvq[i].d, rcvq[i].l, rcvq[i].u, expq[i].d, expq[i].l, expq[i].u);
            end
        end
    endtask

    task automatic test_reset_midline();
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        send_pixel(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
        send_pixel(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        n_checks++;
        if (pix_ready !== 1'b0 || m_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_during: got ready=%b v=%b want 0 0", pix_ready, m_tvalid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (pix_ready !== 1'b0 || m_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_after_edge: got ready=%b v=%b want 0 0", pix_ready, m_tvalid);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_release: got %b want 1", pix_ready); end
        send_pixel(8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b0);
        send_pixel(8'hDD, 8'hEE, 8'hFF, 1'b0, 1'b1);
        drain();
        n_checks++;
        if (rcvq.size() != 2) begin
            n_fail++; $display("FAIL midreset_count: got %0d want 2", rcvq.size());
        end else begin
            n_checks++;
            if (rcvq[0].d[23:0] !== 24'hCCBBAA || rcvq[0].d !== 32'hDDCCBBAA || rcvq[0].u !== 1'b1) begin
                n_fail++; $display("FAIL midreset_word0: got %h u=%b want DDCCBBAA u=1", rcvq[0].d, rcvq[0].u);
            end
            n_checks++;
            if (rcvq[1].d !== 32'h0000FFEE || rcvq[1].l !== 1'b1) begin
                n_fail++; $display("FAIL midreset_word1: got %h l=%b want 0000FFEE l=1", rcvq[1].d, rcvq[1].l);
            end
        end
    endtask

    task automatic test_random();
        int unsigned len;
        bit sof;
        rcvq.delete();
        expq.delete();
        rand_ready = 1'b1;
        for (int ln = 0; ln < 30; ln++) begin
            len = $urandom_range(1, 9);
            sof = (ln % 5 == 0) || ($urandom_range(0, 3) == 0);
            for (int p = 0; p < int'(len); p++) begin
                repeat ($urandom_range(0, 2)) idle_cycle();
                send_pixel(8'($urandom), 8'($urandom), 8'($urandom), sof && (p == 0), p == int'(len) - 1);
            end
        end
        drain();
        n_checks++;
        if (rcvq.size() != expq.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d want %0d", rcvq.size(), expq.size());
        end
        for (int i = 0; i < expq.size(); i++) begin
            n_checks++;
            if (i >= rcvq.size()) begin
                n_fail++; $display("FAIL rand_word%0d: missing, want %h", i, expq[i].d);
            end else if (rcvq[i].d !== expq[i].d || rcvq[i].l !== expq[i].l || rcvq[i].u !== expq[i].u) begin
                n_fail++;
                $display("FAIL rand_word%0d: got %h l=%b u=%b want %h l=%b u=%b",
                         i, rcvq[i].d, rcvq[i].l, rcvq[i].u, expq[i].d, expq[i].l, expq[i].u);
            end
        end
        n_checks++;
        if (protocol_error !== 1'b0) begin
            n_fail++; $display("FAIL rand_proto_clean: got %b want 0", protocol_error);
        end
    endtask

    task automatic test_protocol();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset      = 1'b1;
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        send_pixel(8'h11, 8'h22, 8'h33, 1'b1, 1'b1);
        n_checks++;
        if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL proto_legal: got %b want 0", protocol_error); end
        send_pixel(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
        send_pixel(8'h04, 8'h05, 8'h06, 1'b1, 1'b0);
        n_checks++;
        if (protocol_error !== EXP_ERR) begin
            n_fail++; $display("FAIL proto_set: got %b want %b", protocol_error, EXP_ERR);
        end
        repeat (3) idle_cycle();
        send_pixel(8'h07, 8'h08, 8'h09, 1'b0, 1'b1);
        drain();
        n_checks++;
        if (protocol_error !== EXP_ERR) begin
            n_fail++; $display("FAIL proto_sticky: got %b want %b", protocol_error, EXP_ERR);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_checks++;
        if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL proto_cleared: got %b want 0", protocol_error); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midline();
        test_random();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Downstream stage of the RTU. Consumes the per-pixel RGB stream (red/green/blue, validRead, lastX, Sof) through a valid/ready handshake.
- Packs 24-bit pixels into a 32-bit AXI4-Stream-style word stream for the frame writer / host DMA.
- Buffers output words in a small FIFO and back-pressures the RTU via ReadyExternal.
- Marks start-of-frame (tuser) and end-of-line (tlast).

Parameters:
- FIFO_DEPTH, 4, output word FIFO depth in words; power of two; min 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets).
- pix_valid  in  1  RTU pixel valid (RTU validRead).
- pix_ready  out  1  packer can accept a pixel (drives RTU ReadyExternal).
- pix_red  in  8  red channel.
- pix_green  in  8  green channel.
- pix_blue  in  8  blue channel.
- pix_sof  in  1  first pixel of frame (RTU Sof).
- pix_eol  in  1  last pixel of line (RTU lastX).
- m_tdata  out  32  packed output word.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  word is the final word of a line.
- m_tuser  out  1  word is the first word of a frame.
- protocol_error  out  1  sticky protocol error flag; see Optional Feature.

Behaviour:
- Handshake:
  - Pixel accepted when pix_valid && pix_ready.
  - Word transferred when m_tvalid && m_tready.
  - m_tdata, m_tlast and m_tuser are held stable while m_tvalid && !m_tready.
- Byte order per pixel: red, green, blue. Bytes fill lanes from tdata[7:0] upward, continuously across pixels.
- Phase FSM; state = residual bytes held in the 24-bit accumulator:
  - P0 + pixel -> P3, no word.
  - P3 + pixel -> P2, emit 1 word.
  - P2 + pixel -> P1, emit 1 word.
  - P1 + pixel -> P0, emit 1 word.
- End of line (pix_eol on accepted pixel):
  - After the normal emit, any residual bytes are flushed as one extra word, upper lanes zero-padded. FSM returns to P0.
  - Last word emitted for that pixel carries m_tlast=1.
  - Words per eol pixel: P0 -> 1 (3 bytes + pad); P1 -> 1; P2 -> 2; P3 -> 2.
- Start of frame:
  - pix_sof sets a pending flag; the next word pushed carries m_tuser=1, then the flag clears.
  - If the same cycle pushes two words, only the first carries tuser.
- FIFO:
  - FIFO_DEPTH entries of {tuser, tlast, tdata}.
  - Push of 0, 1 or 2 words per cycle; simultaneous push and pop is supported.
  - Count updates as count + pushes - pop.
- pix_ready = (FIFO_DEPTH - count) >= 2, combinational from the registered count; forced 0 while reset==0. This guarantees no overflow.
- Latency: a word generated by a pixel accepted in cycle N is visible at the FIFO head in N+1 when the FIFO was empty.
- Full: pix_ready=0; no pixel is consumed.
- Empty: m_tvalid=0; m_tdata, m_tlast and m_tuser present the last head value.
- Reset values:
  - m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0.
  - protocol_error=0, pix_ready=0.
  - FSM=P0, sof flag=0, FIFO count=0, pointers=0.
- Reset mid-line or mid-frame: accumulator and FIFO contents are discarded. After release, the packer is ready with pix_ready=1 on the first non-reset cycle.

Optional Feature:
- Macro: PACKER_PROTOCOL_CHECK_EN.
- Defined: protocol_error sets (sticky until reset) when either:
  - pix_sof is accepted while FSM != P0 (frame starts mid-word), or
  - pix_sof is accepted while a line is open (pixels accepted since the last eol).
  - The packer still processes the pixel normally.
- Undefined: protocol_error is tied 0 and no check logic is built.

Test Plan:
- 4-pixel line: (01,02,03),(04,05,06),(07,08,09),(0A,0B,0C eol), sof on first, m_tready=1 -> words 0x04030201 (tuser=1), 0x08070605, 0x0C0B0A09 (tlast=1).
- 1-pixel line: (11,22,33) sof+eol -> single word 0x00332211 with tuser=1 and tlast=1; FSM back to P0.
- 2-pixel line: (01,02,03),(04,05,06 eol) -> 0x04030201, then 0x00000605 tlast=1; both words pushed in the eol cycle.
- Backpressure: FIFO_DEPTH=4, m_tready=0, stream 8-pixel line -> pix_ready drops to 0 when count>=3, no word lost or reordered, head stable. Raise m_tready -> all 6 words out in order, last with tlast.
- Reset mid-line: 2 pixels accepted, reset=0 for 1 cycle -> m_tvalid=0 and pix_ready=0 during reset, pix_ready=1 after. Next line starting (AA,BB,CC) yields first word 0x..CCBBAA with no stale bytes.
- PACKER_PROTOCOL_CHECK_EN defined: sof asserted on 2nd pixel of a line -> protocol_error=1 next cycle and stays 1 until reset. Undefined: stays 0.
